// File: rtl/sequential_multiplier_signed_if.sv
// Operand/result bundle for the sequential signed/unsigned multiplier.
// Handshake: a request transfers on a rising edge where start=1 and ready=1; done pulses once when Product updates.
interface sequential_multiplier_signed_if #(
  parameter int WORD_LENGTH = 8
);
  logic                       start;
  logic                       signed_mode;
  logic [WORD_LENGTH-1:0]     Multiplier;
  logic [WORD_LENGTH-1:0]     Multiplicand;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic [2*WORD_LENGTH-1:0]   Product;
  logic [1:0]                 state_dbg;

  modport master (
    output start, signed_mode, Multiplier, Multiplicand,
    input  ready, busy, done, Product, state_dbg
  );

  modport slave (
    input  start, signed_mode, Multiplier, Multiplicand,
    output ready, busy, done, Product, state_dbg
  );
endinterface

// File: rtl/sequential_multiplier_signed.sv
// Shift-add multiplier, one multiplier bit per clock, with signed mode,
// zero-operand early exit and a registered product held between operations.
module sequential_multiplier_signed #(
  parameter int WORD_LENGTH = 8
) (
  input  logic clk,
  input  logic reset,
  sequential_multiplier_signed_if.slave bus
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 3
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [2*W-1:0]  product_q, product_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;

  logic [W-1:0]    mag_mplier;
  logic [W-1:0]    mag_mcand;
  logic            zero_op;

  // Magnitudes stay W bits unsigned, so the most negative value maps to 2^(W-1).
  always_comb begin
    mag_mplier = bus.Multiplier;
    mag_mcand  = bus.Multiplicand;
    if (bus.signed_mode && bus.Multiplier[W-1])   mag_mplier = ~bus.Multiplier + 1'b1;
    if (bus.signed_mode && bus.Multiplicand[W-1]) mag_mcand  = ~bus.Multiplicand + 1'b1;
    zero_op = (bus.Multiplier == '0) || (bus.Multiplicand == '0);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (zero_op) begin
            product_d = '0;
            sign_d    = 1'b0;
            state_d   = S_DONE;
          end else begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, mag_mcand};
            mplier_d = mag_mplier;
            cnt_d    = '0;
            sign_d   = bus.signed_mode & (bus.Multiplier[W-1] ^ bus.Multiplicand[W-1]);
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        product_d = sign_q ? (~acc_q + 1'b1) : acc_q;
        state_d   = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
    end
  end

  // Status is decoded straight from state so reset clears it without waiting for an edge.
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done      = (state_q == S_DONE);
  assign bus.Product   = product_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_sequential_multiplier_signed.sv
// Self-checking bench for sequential_multiplier_signed (W=8): directed and random
// operations checked against a behavioural product model through an expected queue.
module tb_sequential_multiplier_signed;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [2*W-1:0] exp_q[$];

  sequential_multiplier_signed_if #(.WORD_LENGTH(W)) bus ();

  sequential_multiplier_signed #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint sa, sb, p;
    logic [63:0] pv;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[W-1]) sa = sa - (longint'(1) << W);
    if (sm && b[W-1]) sb = sb - (longint'(1) << W);
    p  = sa * sb;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // driver tasks: caller is at a negedge with ready=1
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    bus.start        = 1'b1;
    bus.Multiplier   = a;
    bus.Multiplicand = b;
    bus.signed_mode  = sm;
    exp_q.push_back(model(a, b, sm));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Counts negedges from the one after E0 until done is seen.
  task automatic wait_done(output int lat, output int busy_n, output logic to);
    lat = 0; busy_n = 0; to = 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++;
    if (bus.Product !== '0) begin n_fail++; $display("FAIL reset_product: got %h want 0", bus.Product); end
  endtask

  task automatic test_unsigned();
    logic [W-1:0] ta[4] = '{8'd6, 8'd251, 8'd255, 8'd1};
    logic [W-1:0] tb[4] = '{8'd3, 8'd2,   8'd255, 8'd1};
    logic [2*W-1:0] ex;
    int lat, bn;
    logic to;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      drive_op(ta[i], tb[i], 1'b0);
      wait_done(lat, bn, to);
      ex = exp_q.pop_front();
      n_checks++;
      if (to || lat != W + 1) begin n_fail++; $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, lat, W + 1); end
      n_checks++;
      if (bus.Product !== ex) begin n_fail++; $display("FAIL unsigned_product[%0d]: got %h want %h", i, bus.Product, ex); end
      if (i == 0) begin
        n_checks++;
        if (bn != W + 1) begin n_fail++; $display("FAIL unsigned_busy_cycles: got %0d want %0d", bn, W + 1); end
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
          n_fail++; $display("FAIL unsigned_ready_after_done: got ready=%b done=%b want 1/0", bus.ready, bus.done);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta[5] = '{8'hFB, 8'h80, 8'h7F, 8'h03, 8'hFF};
    logic [W-1:0] tb[5] = '{8'h03, 8'h80, 8'hFF, 8'hFB, 8'hFF};
    logic [2*W-1:0] ex;
    int lat, bn;
    logic to;
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      drive_op(ta[i], tb[i], 1'b1);
      wait_done(lat, bn, to);
      ex = exp_q.pop_front();
      n_checks++;
      if (to || bus.Product !== ex) begin n_fail++; $display("FAIL signed_product[%0d]: got %h want %h", i, bus.Product, ex); end
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] ta[2] = '{8'd0,   8'hF9};
    logic [W-1:0] tb[2] = '{8'd200, 8'd0};
    logic         tm[2] = '{1'b0,   1'b1};
    logic [2*W-1:0] ex;
    int lat, bn;
    logic to;
    for (int i = 0; i < 2; i++) begin
      wait_ready();
      drive_op(ta[i], tb[i], tm[i]);
      wait_done(lat, bn, to);
      ex = exp_q.pop_front();
      n_checks++;
      if (to || lat != 0) begin n_fail++; $display("FAIL zero_latency[%0d]: got %0d want 0", i, lat); end
      n_checks++;
      if (bus.Product !== ex) begin n_fail++; $display("FAIL zero_product[%0d]: got %h want %h", i, bus.Product, ex); end
      @(negedge clk);
      n_checks++;
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready[%0d]: got %b want 1", i, bus.ready); end
    end
  endtask

  task automatic test_ignore_start();
    logic [2*W-1:0] ex, got;
    int pulses;
    wait_ready();
    drive_op(8'd100, 8'd3, 1'b0);
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        bus.start = 1'b1; bus.Multiplier = 8'd7; bus.Multiplicand = 8'd9; bus.signed_mode = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin pulses++; got = bus.Product; end
      @(negedge clk);
    end
    ex = exp_q.pop_front();
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (got !== ex) begin n_fail++; $display("FAIL ignore_product: got %h want %h", got, ex); end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL ignore_idle_after: got ready=%b want 1", bus.ready); end
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] ex;
    int pulses, lat, bn;
    logic to;
    wait_ready();
    bus.start = 1'b1; bus.Multiplier = 8'd6; bus.Multiplicand = 8'd3; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got ready=%b busy=%b done=%b want 1/0/0", bus.ready, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.Product !== '0) begin n_fail++; $display("FAIL midreset_product: got %h want 0", bus.Product); end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
    drive_op(8'd6, 8'd3, 1'b0);
    wait_done(lat, bn, to);
    ex = exp_q.pop_front();
    n_checks++;
    if (to || bus.Product !== ex) begin n_fail++; $display("FAIL midreset_followup: got %h want %h", bus.Product, ex); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[5] = '{8'd13, 8'hF0, 8'd255, 8'd2,   8'h81};
    logic [W-1:0] tb[5] = '{8'd11, 8'h10, 8'd2,   8'd128, 8'h7F};
    logic         tm[5] = '{1'b0,  1'b1,  1'b0,   1'b1,   1'b1};
    logic [2*W-1:0] ex, prev;
    int cnt, unstable;
    wait_ready();
    prev = bus.Product;
    unstable = 0;
    bus.start = 1'b1; bus.Multiplier = ta[0]; bus.Multiplicand = tb[0]; bus.signed_mode = tm[0];
    exp_q.push_back(model(ta[0], tb[0], tm[0]));
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      while (bus.done !== 1'b1 && cnt < 200) begin
        if (bus.Product !== prev) unstable++;
        @(negedge clk);
        cnt++;
      end
      ex = exp_q.pop_front();
      n_checks++;
      if (bus.Product !== ex) begin n_fail++; $display("FAIL b2b_product[%0d]: got %h want %h", k, bus.Product, ex); end
      n_checks++;
      if (cnt != ((k == 0) ? W + 2 : W + 3)) begin
        n_fail++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, cnt, (k == 0) ? W + 2 : W + 3);
      end
      prev = bus.Product;
      if (k < 4) begin
        bus.Multiplier = ta[k+1]; bus.Multiplicand = tb[k+1]; bus.signed_mode = tm[k+1];
        exp_q.push_back(model(ta[k+1], tb[k+1], tm[k+1]));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cnt = 1;
    end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL b2b_product_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic sm;
    logic [2*W-1:0] ex;
    int lat, bn;
    logic to;
    for (int i = 0; i < 12; i++) begin
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      if (i == 5) a = '0;
      wait_ready();
      drive_op(a, b, sm);
      wait_done(lat, bn, to);
      ex = exp_q.pop_front();
      n_checks++;
      if (to || bus.Product !== ex) begin
        n_fail++; $display("FAIL random[%0d] %h*%h sm=%b: got %h want %h", i, a, b, sm, bus.Product, ex);
      end
      n_checks++;
      if (lat != (((a == '0) || (b == '0)) ? 0 : W + 1)) begin
        n_fail++; $display("FAIL random_latency[%0d]: got %0d", i, lat);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.Multiplier   = '0;
    bus.Multiplicand = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_unsigned();
    test_signed();
    test_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
